// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit and for the
// control unit's MFHI/MFLO stall logic.
//   mdu_op_e    : operation encodings carried on the Op input
//   mdu_state_e : FSM state encoding
//   MDU_WIDTH   : default operand / HI / LO width
//   MDU_CNT_W   : default iteration counter width (2**MDU_CNT_W == MDU_WIDTH)
//   MDU_LATENCY : cycles from Start to Done for an iterative operation
package mdu_pkg;

  localparam int MDU_WIDTH   = 32;
  localparam int MDU_CNT_W   = 5;
  localparam int MDU_LATENCY = MDU_WIDTH + 2;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: iterative datapath of the multiply/divide unit.
// Holds the 2*WIDTH accumulator {acc_hi, acc_lo}, the second operand and the
// iteration counter, and performs one shift-add (multiply, LSB first) or one
// restoring shift-subtract (divide, MSB first) per enabled cycle.
// Ports:
//   CLK, RST   clock, asynchronous active-high reset
//   load       clear accumulator high half, load opa into the low half,
//              latch opb, clear counter
//   step       perform one iteration
//   is_div     1 = divide step, 0 = multiply step
//   opa        multiplier / dividend magnitude
//   opb        multiplicand / divisor magnitude
//   acc_hi     product high word / partial remainder
//   acc_lo     product low word / quotient
//   last       counter is at its final iteration (WIDTH-1)
module mdu_iter_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo,
  output logic             last
);

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   mul_sum, rem_sh, div_diff;
  logic [WIDTH-1:0] hi_nx, lo_nx;

  always_comb begin
    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole 2*WIDTH+1 result right by one.
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    // Divide: shift the next dividend bit into the remainder; the extra top
    // bit of the difference acts as the borrow (1 = restore).
    rem_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = rem_sh - {1'b0, b_q};
    hi_nx    = mul_sum[WIDTH:1];
    lo_nx    = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (is_div) begin
      hi_nx = div_diff[WIDTH] ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_nx = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= opa;
      b_q   <= opb;
      cnt_q <= '0;
    end else if (step) begin
      hi_q  <= hi_nx;
      lo_q  <= lo_nx;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign acc_hi = hi_q;
  assign acc_lo = lo_q;
  assign last   = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO, plus
// MTHI/MTLO writes, with a Busy/Done handshake for MFHI/MFLO stalling.
// Optional build macro: MDU_FAST_MUL_EN -- multiplies use a single-cycle
// full multiplier and skip RUN (Done in cycle 2); divides stay iterative.
// Ports:
//   CLK, RST      clock, asynchronous active-high reset
//   Start, Op     operation request (sampled only in IDLE) and opcode
//   SrcA, SrcB    multiplicand/dividend, multiplier/divisor
//   WEHi, WELo,WD MTHI/MTLO write enables and data (IDLE only)
//   HI, LO        result registers
//   Busy          operation in progress
//   Done          one-cycle pulse, new HI/LO valid
//
// state | meaning
// IDLE  | waiting for Start; MTHI/MTLO writes accepted
// RUN   | one iteration per cycle in mdu_iter_core
// FIX   | apply result signs, write HI/LO on the closing edge
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             WEHi,
  input  logic             WELo,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done
);

  mdu_state_e state_q;
  mdu_op_e    op_q;
  logic       sa_q, sb_q, div0_q;

  logic             op_signed, start_ok, div0_in, is_div;
  logic [WIDTH-1:0] mag_a, mag_b, core_a;
  logic [WIDTH-1:0] acc_hi, acc_lo;
  logic             core_last;

  logic [2*WIDTH-1:0] prod_mag, prod_res;
  logic [WIDTH-1:0]   quo_res, rem_res, hi_res, lo_res;

  always_comb begin
    op_signed = (Op == OP_MULT) || (Op == OP_DIV);
    start_ok  = Start && (state_q == IDLE);
    div0_in   = Op[1] && (SrcB == '0);
    mag_a     = (op_signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    mag_b     = (op_signed && SrcB[WIDTH-1]) ? -SrcB : SrcB;
    // On divide-by-zero the raw dividend is parked in the accumulator low
    // half so FIX can return it untouched as HI.
    core_a    = div0_in ? SrcA : mag_a;
    is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
  end

  mdu_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .CLK    (CLK),
    .RST    (RST),
    .load   (start_ok),
    .step   (state_q == RUN),
    .is_div (is_div),
    .opa    (core_a),
    .opb    (mag_b),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .last   (core_last)
  );

`ifdef MDU_FAST_MUL_EN
  logic [WIDTH-1:0] fast_a_q, fast_b_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fast_a_q <= '0;
      fast_b_q <= '0;
    end else if (start_ok) begin
      fast_a_q <= mag_a;
      fast_b_q <= mag_b;
    end
  end

  assign prod_mag = {{WIDTH{1'b0}}, fast_a_q} * {{WIDTH{1'b0}}, fast_b_q};
`else
  assign prod_mag = {acc_hi, acc_lo};
`endif

  always_comb begin
    prod_res = (sa_q ^ sb_q) ? -prod_mag : prod_mag;
    quo_res  = (sa_q ^ sb_q) ? -acc_lo : acc_lo;
    // Remainder follows the dividend's sign.
    rem_res  = sa_q ? -acc_hi : acc_hi;
    if (div0_q) begin
      hi_res = acc_lo;
      lo_res = '1;
    end else if (is_div) begin
      hi_res = rem_res;
      lo_res = quo_res;
    end else begin
      hi_res = prod_res[2*WIDTH-1:WIDTH];
      lo_res = prod_res[WIDTH-1:0];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div0_q  <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (WEHi) HI <= WD;
          if (WELo) LO <= WD;
          if (Start) begin
            op_q   <= mdu_op_e'(Op);
            sa_q   <= op_signed & SrcA[WIDTH-1];
            sb_q   <= op_signed & SrcB[WIDTH-1];
            div0_q <= div0_in;
            if (div0_in) state_q <= FIX;
`ifdef MDU_FAST_MUL_EN
            else if (!Op[1]) state_q <= FIX;
`endif
            else state_q <= RUN;
          end
        end
        RUN: begin
          if (core_last) state_q <= FIX;
        end
        FIX: begin
          HI      <= hi_res;
          LO      <= lo_res;
          Done    <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
  import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = MDU_LATENCY;
`endif
  localparam int DIV_LAT = MDU_LATENCY;

  logic        CLK, RST, Start, WEHi, WELo, Busy, Done;
  logic [1:0]  Op;
  logic [31:0] SrcA, SrcB, WD, HI, LO;

  int compared   = 0;
  int mismatched = 0;

  mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .Start (Start),
    .Op    (Op),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .WEHi  (WEHi),
    .WELo  (WELo),
    .WD    (WD),
    .HI    (HI),
    .LO    (LO),
    .Busy  (Busy),
    .Done  (Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one operation in cycle 0 and follow it to Done (bounded).
  // inj != 0: in that cycle pulse a second Start (SrcA=9) and WELo (WD=0x77),
  //           both of which must be ignored; hold_lo is the LO expected
  //           to persist while busy.
  // wehi_start: assert WEHi with Start; HI must show WD in cycle 1.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int inj,
                        input logic [31:0] hold_lo, input bit wehi_start);
    int cyc;
    int busy_n;
    bit seen;
    @(negedge CLK);
    Op = op; SrcA = a; SrcB = b; Start = 1'b1;
    if (wehi_start) begin WEHi = 1'b1; WD = 32'hDEAD_BEEF; end
    cyc = 0; busy_n = 0; seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(negedge CLK);
      cyc++;
      Start = 1'b0; WEHi = 1'b0; WELo = 1'b0;
      if (wehi_start && cyc == 1) chk({tag, "_mthi_with_start"}, HI, 32'hDEAD_BEEF);
      if (inj != 0 && cyc == inj) begin
        Start = 1'b1; SrcA = 32'd9; WELo = 1'b1; WD = 32'h77;
      end
      if (inj != 0 && cyc == inj + 2) chk({tag, "_lo_hold_busy"}, LO, hold_lo);
      if (Busy) busy_n++;
      if (Done) seen = 1'b1;
    end
    chk({tag, "_done_cycle"}, cyc, exp_lat);
    chk({tag, "_busy_cycles"}, busy_n, exp_lat - 1);
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
    @(negedge CLK);
    chk({tag, "_idle_after"}, {30'd0, Busy, Done}, 32'd0);
  endtask

  initial begin
    int dones;
    RST = 1'b1; Start = 1'b0; Op = 2'b00; SrcA = '0; SrcB = '0;
    WEHi = 1'b0; WELo = 1'b0; WD = '0;
    repeat (2) @(negedge CLK);
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    chk("reset_busy_done", {30'd0, Busy, Done}, 32'd0);
    RST = 1'b0;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT,
           32'hFFFF_FFFE, 32'h0000_0001, 0, 32'h0, 1'b0);
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, MUL_LAT,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 32'h0, 1'b0);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, DIV_LAT,
           32'd2, 32'd14, 0, 32'h0, 1'b0);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 32'h0, 1'b0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT,
           32'h0, 32'h8000_0000, 0, 32'h0, 1'b0);
    run_op("div_by0", OP_DIV, 32'h0000_1234, 32'h0, 2,
           32'h0000_1234, 32'hFFFF_FFFF, 0, 32'h0, 1'b0);

    // Idle MTHI
    @(negedge CLK);
    WEHi = 1'b1; WD = 32'hA5A5_A5A5;
    @(negedge CLK);
    WEHi = 1'b0;
    chk("mthi_hi", HI, 32'hA5A5_A5A5);
    chk("mthi_lo_kept", LO, 32'hFFFF_FFFF);

    // Start and MTLO during Busy are ignored
    run_op("multu_2x3_inj", OP_MULTU, 32'd2, 32'd3, MUL_LAT,
           32'h0, 32'd6, (MUL_LAT > 6) ? 5 : 0, 32'hFFFF_FFFF, 1'b0);

    // Reset in the middle of an operation
    @(negedge CLK);
    Op = OP_MULTU; SrcA = 32'd5; SrcB = 32'd5; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (9) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("abort_hi", HI, 32'h0);
    chk("abort_lo", LO, 32'h0);
    chk("abort_busy_done", {30'd0, Busy, Done}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (Done || Busy) dones++;
    end
    chk("abort_no_done", dones, 0);

    run_op("multu_5x5_after", OP_MULTU, 32'd5, 32'd5, MUL_LAT,
           32'h0, 32'd25, 0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
